// File: rtl/mem_stage_sramlike.sv
// Memory pipeline stage for an SRAM-like data port: holds one entry, waits for
// the load response, forwards or latches it, and formats load data for WB.
module mem_stage_sramlike #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned META_W      = 136,
  parameter int unsigned MAX_DISCARD = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     es_to_ms_valid,
  input  logic [META_W+XLEN+5:0]   es_to_ms_bus,
  output logic                     ms_allowin,
  input  logic                     ws_allowin,
  output logic                     ms_to_ws_valid,
  output logic [META_W+XLEN:0]     ms_to_ws_bus,
  input  logic                     data_sram_data_ok,
  input  logic [XLEN-1:0]          data_sram_rdata,
  input  logic                     flush,
  output logic                     ms_ex,
  output logic                     out_ms_valid
);

  localparam int unsigned OFF_W = $clog2(XLEN / 8);
  localparam int unsigned CNT_W = (MAX_DISCARD < 2) ? 1 : $clog2(MAX_DISCARD + 1);
  localparam int unsigned BUS_W = META_W + XLEN + 6;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_nxt;
  logic [XLEN-1:0]    data_q;

  // Captured entry payload (not reset; only meaningful while valid)
  logic [META_W-1:0]  meta_q;
  logic               ex_q;
  logic [1:0]         ld_size_q;
  logic               ld_unsigned_q;
  logic               res_from_mem_q;
  logic [XLEN-1:0]    result_q;

  // Incoming entry fields
  logic [META_W-1:0]  in_meta;
  logic               in_ex;
  logic               in_wait_data;
  logic [1:0]         in_ld_size;
  logic               in_ld_unsigned;
  logic               in_res_from_mem;
  logic [XLEN-1:0]    in_result;

  logic               valid;
  logic               live_ok;
  logic               drop_ok;
  logic               ready_go;
  logic               capture;

  logic [XLEN-1:0]    load_raw;
  logic [XLEN-1:0]    load_shifted;
  logic [XLEN-1:0]    load_mask;
  logic               load_sign;
  logic [XLEN-1:0]    load_ext;
  logic [XLEN-1:0]    final_result;

  assign in_result       = es_to_ms_bus[XLEN-1:0];
  assign in_res_from_mem = es_to_ms_bus[XLEN];
  assign in_ld_unsigned  = es_to_ms_bus[XLEN+1];
  assign in_ld_size      = es_to_ms_bus[XLEN+3:XLEN+2];
  assign in_wait_data    = es_to_ms_bus[XLEN+4];
  assign in_ex           = es_to_ms_bus[XLEN+5];
  assign in_meta         = es_to_ms_bus[BUS_W-1:XLEN+6];

  // Handshake: responses are stale while the discard counter is non-zero
  assign valid          = (state_q != ST_EMPTY);
  assign live_ok        = data_sram_data_ok && (cnt_q == '0);
  assign drop_ok        = data_sram_data_ok && (cnt_q != '0);
  assign ready_go       = (state_q == ST_HOLD) || ((state_q == ST_WAIT) && live_ok);
  assign ms_allowin     = !valid || (ready_go && ws_allowin);
  assign capture        = es_to_ms_valid && ms_allowin;
  assign ms_to_ws_valid = valid && ready_go;
  assign out_ms_valid   = valid;
  assign ms_ex          = valid && ex_q;

  // Load formatting: lane select, size mask, sign/zero extension
  assign load_raw     = (state_q == ST_WAIT) ? data_sram_rdata : data_q;
  assign load_shifted = load_raw >> {result_q[OFF_W-1:0], 3'b000};

  always_comb begin
    load_mask = '1;
    load_sign = load_shifted[XLEN-1];
    case (ld_size_q)
      2'd0: begin
        load_mask = XLEN'(8'hFF);
        load_sign = load_shifted[7];
      end
      2'd1: begin
        load_mask = XLEN'(16'hFFFF);
        load_sign = load_shifted[15];
      end
      2'd2: begin
        load_mask = XLEN'(32'hFFFF_FFFF);
        load_sign = load_shifted[31];
      end
      default: begin
        load_mask = '1;
        load_sign = load_shifted[XLEN-1];
      end
    endcase
  end

  assign load_ext     = (load_shifted & load_mask) |
                        (~load_mask & {XLEN{load_sign & ~ld_unsigned_q}});
  assign final_result = res_from_mem_q ? load_ext : result_q;
  assign ms_to_ws_bus = {meta_q, ex_q, final_result};

  // Next state and discard counter
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    if (drop_ok) begin
      cnt_nxt = cnt_q - CNT_W'(1);
    end
    if (flush && (state_q == ST_WAIT) && !live_ok && (cnt_nxt != CNT_W'(MAX_DISCARD))) begin
      cnt_nxt = cnt_nxt + CNT_W'(1);
    end
    if (flush) begin
      state_nxt = ST_EMPTY;
    end else if (capture) begin
      state_nxt = (in_wait_data && !in_ex) ? ST_WAIT : ST_HOLD;
    end else if (ready_go && ws_allowin) begin
      state_nxt = ST_EMPTY;
    end else if ((state_q == ST_WAIT) && live_ok) begin
      state_nxt = ST_HOLD;
    end
  end

  // State, counter and response data registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      if ((state_q == ST_WAIT) && live_ok) begin
        data_q <= data_sram_rdata;
      end
    end
  end

  // Entry payload capture
  always_ff @(posedge clk) begin
    if (capture) begin
      meta_q         <= in_meta;
      ex_q           <= in_ex;
      ld_size_q      <= in_ld_size;
      ld_unsigned_q  <= in_ld_unsigned;
      res_from_mem_q <= in_res_from_mem;
      result_q       <= in_result;
    end
  end

endmodule

// File: tb/tb_mem_stage_sramlike.sv
// Randomized and directed checks of mem_stage_sramlike against a transaction-level model.
module tb_mem_stage_sramlike;

  localparam int unsigned X    = 32;
  localparam int unsigned M    = 136;
  localparam int unsigned BW   = M + X + 6;
  localparam int unsigned OW   = M + X + 1;
  localparam int          MAXD = 2;
  localparam int unsigned X2   = 64;
  localparam int unsigned M2   = 8;
  localparam int unsigned BW2  = M2 + X2 + 6;
  localparam int unsigned OW2  = M2 + X2 + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          es_to_ms_valid;
  logic [BW-1:0] es_to_ms_bus;
  logic          ms_allowin;
  logic          ws_allowin;
  logic          ms_to_ws_valid;
  logic [OW-1:0] ms_to_ws_bus;
  logic          data_sram_data_ok;
  logic [X-1:0]  data_sram_rdata;
  logic          flush;
  logic          ms_ex;
  logic          out_ms_valid;

  logic           reset_w;
  logic           es_to_ms_valid_w;
  logic [BW2-1:0] es_to_ms_bus_w;
  logic           ms_allowin_w;
  logic           ws_allowin_w;
  logic           ms_to_ws_valid_w;
  logic [OW2-1:0] ms_to_ws_bus_w;
  logic           data_sram_data_ok_w;
  logic [X2-1:0]  data_sram_rdata_w;
  logic           flush_w;
  logic           ms_ex_w;
  logic           out_ms_valid_w;

  mem_stage_sramlike #(.XLEN(X), .META_W(M), .MAX_DISCARD(MAXD)) dut (
    .clk(clk), .reset(reset), .es_to_ms_valid(es_to_ms_valid), .es_to_ms_bus(es_to_ms_bus),
    .ms_allowin(ms_allowin), .ws_allowin(ws_allowin), .ms_to_ws_valid(ms_to_ws_valid),
    .ms_to_ws_bus(ms_to_ws_bus), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata), .flush(flush), .ms_ex(ms_ex), .out_ms_valid(out_ms_valid)
  );

  mem_stage_sramlike #(.XLEN(X2), .META_W(M2), .MAX_DISCARD(MAXD)) dut64 (
    .clk(clk), .reset(reset_w), .es_to_ms_valid(es_to_ms_valid_w), .es_to_ms_bus(es_to_ms_bus_w),
    .ms_allowin(ms_allowin_w), .ws_allowin(ws_allowin_w), .ms_to_ws_valid(ms_to_ws_valid_w),
    .ms_to_ws_bus(ms_to_ws_bus_w), .data_sram_data_ok(data_sram_data_ok_w),
    .data_sram_rdata(data_sram_rdata_w), .flush(flush_w), .ms_ex(ms_ex_w),
    .out_ms_valid(out_ms_valid_w)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Single comparison point
  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: one slot, whether it still needs data, stale responses owed
  bit            m_valid;
  bit            m_need;
  logic [BW-1:0] m_bus;
  logic [X-1:0]  m_data;
  int            m_stale;

  logic          s_allowin;
  logic          s_vout;
  logic          s_ex;
  logic          s_valid;
  logic [OW-1:0] s_bus;

  function automatic logic [63:0] ext_load(input logic [63:0] raw, input int off, input int size,
                                           input bit uns, input int xlen);
    logic [63:0] v;
    logic [63:0] mask;
    int nb;
    nb = (size == 3) ? 64 : (8 << size);
    if (nb > xlen) nb = xlen;
    v    = raw >> (off * 8);
    mask = (nb == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << nb) - 64'd1);
    v    = v & mask;
    if (!uns && v[nb-1]) v = v | ~mask;
    if (xlen == 32) v = v & 64'h0000_0000_FFFF_FFFF;
    return v;
  endfunction

  function automatic logic [BW-1:0] mk(input logic [M-1:0] meta, input bit ex, input bit wt,
                                       input logic [1:0] sz, input bit uns, input bit rfm,
                                       input logic [X-1:0] res);
    return {meta, ex, wt, sz, uns, rfm, res};
  endfunction

  function automatic logic [M-1:0] rnd_meta();
    logic [159:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return t[M-1:0];
  endfunction

  // One clock of stimulus, comparison against the model, model update
  task automatic step(input bit rst, input bit esv, input logic [BW-1:0] bus, input bit wsa,
                      input bit dok, input logic [X-1:0] rd, input bit fl);
    bit            live;
    bit            ready;
    bit            allow;
    logic [X-1:0]  raw;
    logic [X-1:0]  fin;
    logic [OW-1:0] ebus;
    int            st;
    reset = rst; es_to_ms_valid = esv; es_to_ms_bus = bus; ws_allowin = wsa;
    data_sram_data_ok = dok; data_sram_rdata = rd; flush = fl;
    #4;
    s_allowin = ms_allowin; s_vout = ms_to_ws_valid; s_ex = ms_ex;
    s_valid = out_ms_valid; s_bus = ms_to_ws_bus;
    live  = dok && (m_stale == 0);
    ready = m_valid && (!m_need || live);
    allow = !m_valid || (ready && wsa);
    raw   = m_need ? rd : m_data;
    fin   = m_bus[X] ? X'(ext_load(64'(raw), int'(m_bus[1:0]), int'(m_bus[X+3:X+2]), m_bus[X+1], 32))
                     : m_bus[X-1:0];
    ebus  = {m_bus[BW-1:X+6], m_bus[X+5], fin};
    if (!rst) begin
      check("allowin", 256'(ms_allowin), 256'(allow));
      check("out_ms_valid", 256'(out_ms_valid), 256'(m_valid));
      check("ms_ex", 256'(ms_ex), 256'(m_valid && m_bus[X+5]));
      check("ms_to_ws_valid", 256'(ms_to_ws_valid), 256'(ready));
      if (ready) check("ms_to_ws_bus", 256'(ms_to_ws_bus), 256'(ebus));
    end
    if (rst) begin
      m_valid = 0; m_need = 0; m_data = '0; m_stale = 0;
    end else begin
      st = m_stale;
      if (dok && st > 0) st--;
      if (fl && m_valid && m_need && !live && st < MAXD) st++;
      if (m_valid && m_need && live) begin
        m_data = rd;
        m_need = 0;
      end
      if (fl) m_valid = 0;
      else if (esv && allow) begin
        m_valid = 1; m_bus = bus; m_need = bus[X+4] && !bus[X+5];
      end else if (ready && wsa) m_valid = 0;
      m_stale = st;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit wsa);
    step(0, 0, '0, wsa, 0, '0, 0);
  endtask

  // 64-bit instance: capture one load, answer it next cycle, check the formatted result
  task automatic step64(input string tag, input logic [63:0] res, input logic [1:0] sz,
                        input bit uns, input logic [63:0] rd, input logic [63:0] exp);
    es_to_ms_valid_w = 1; es_to_ms_bus_w = {8'hA5, 1'b0, 1'b1, sz, uns, 1'b1, res};
    ws_allowin_w = 1; data_sram_data_ok_w = 0;
    #4;
    check({tag, "_allowin"}, 256'(ms_allowin_w), 256'(1));
    @(posedge clk); #1;
    es_to_ms_valid_w = 0; data_sram_data_ok_w = 1; data_sram_rdata_w = rd;
    #4;
    check({tag, "_vout"}, 256'(ms_to_ws_valid_w), 256'(1));
    check({tag, "_final"}, 256'(ms_to_ws_bus_w[X2-1:0]), 256'(exp));
    check({tag, "_meta"}, 256'(ms_to_ws_bus_w[OW2-1:X2+1]), 256'(8'hA5));
    @(posedge clk); #1;
    data_sram_data_ok_w = 0;
    #4;
    check({tag, "_empty"}, 256'(out_ms_valid_w), 256'(0));
    @(posedge clk); #1;
  endtask

  logic [M-1:0] meta;
  logic [BW-1:0] e;

  initial begin
    reset = 1; es_to_ms_valid = 0; es_to_ms_bus = '0; ws_allowin = 0;
    data_sram_data_ok = 0; data_sram_rdata = '0; flush = 0;
    reset_w = 1; es_to_ms_valid_w = 0; es_to_ms_bus_w = '0; ws_allowin_w = 0;
    data_sram_data_ok_w = 0; data_sram_rdata_w = '0; flush_w = 0;
    m_valid = 0; m_need = 0; m_bus = '0; m_data = '0; m_stale = 0;
    meta = M'(64'hDEAD_BEEF_0000_0001);

    // Reset values
    step(1, 0, '0, 0, 0, '0, 0);
    step(1, 0, '0, 0, 0, '0, 0);
    idle(0);
    check("rst_allowin", 256'(s_allowin), 256'(1));
    check("rst_valid", 256'(s_valid), 256'(0));
    check("rst_vout", 256'(s_vout), 256'(0));
    check("rst_ex", 256'(s_ex), 256'(0));

    // ld.b offset 3, zero-latency forward
    step(0, 1, mk(meta, 0, 1, 2'd0, 0, 1, 32'h0000_1003), 1, 0, '0, 0);
    step(0, 0, '0, 1, 1, 32'h80FF_0000, 0);
    check("ldb_vout", 256'(s_vout), 256'(1));
    check("ldb_final", 256'(s_bus[X-1:0]), 256'(32'hFFFF_FF80));

    // ld.hu offset 2 with WB stalled: held stable then handed off
    step(0, 1, mk(meta, 0, 1, 2'd1, 1, 1, 32'h0000_2002), 1, 0, '0, 0);
    step(0, 0, '0, 0, 1, 32'h8001_1234, 0);
    check("ldhu_first", 256'(s_bus[X-1:0]), 256'(32'h0000_8001));
    for (int i = 0; i < 2; i++) begin
      idle(0);
      check("ldhu_hold_vout", 256'(s_vout), 256'(1));
      check("ldhu_hold_bus", 256'(s_bus[X-1:0]), 256'(32'h0000_8001));
    end
    idle(1);
    check("ldhu_handoff", 256'(s_bus[X-1:0]), 256'(32'h0000_8001));
    idle(0);
    check("ldhu_gone", 256'(s_valid), 256'(0));

    // Flush in WAIT: the late response is dropped, the next one serves the new entry
    step(0, 1, mk(meta, 0, 1, 2'd0, 1, 1, 32'h0000_3000), 1, 0, '0, 0);
    step(0, 0, '0, 1, 0, '0, 1);
    step(0, 1, mk(meta, 0, 1, 2'd0, 1, 1, 32'h0000_3000), 1, 0, '0, 0);
    check("flush_empty", 256'(s_valid), 256'(0));
    step(0, 0, '0, 1, 1, 32'h0000_DEAD, 0);
    check("flush_drop", 256'(s_vout), 256'(0));
    step(0, 0, '0, 1, 1, 32'h0000_00AB, 0);
    check("flush_serve", 256'(s_vout), 256'(1));
    check("flush_data", 256'(s_bus[X-1:0]), 256'(32'h0000_00AB));

    // Exception entry skips the wait
    step(0, 1, mk(meta, 1, 1, 2'd2, 0, 0, 32'h0000_4000), 1, 0, '0, 0);
    idle(1);
    check("ex_ms_ex", 256'(s_ex), 256'(1));
    check("ex_vout", 256'(s_vout), 256'(1));

    // Reset in WAIT: pulse ignored, counter clear
    step(0, 1, mk(meta, 0, 1, 2'd2, 0, 1, 32'h0000_5000), 1, 0, '0, 0);
    step(0, 0, '0, 1, 0, '0, 1);
    step(0, 1, mk(meta, 0, 1, 2'd2, 0, 1, 32'h0000_5000), 1, 0, '0, 0);
    step(1, 0, '0, 1, 0, '0, 0);
    step(0, 0, '0, 1, 1, 32'h1111_1111, 0);
    check("rstw_valid", 256'(s_valid), 256'(0));
    step(0, 1, mk(meta, 0, 1, 2'd2, 0, 1, 32'h0000_5000), 1, 0, '0, 0);
    step(0, 0, '0, 1, 1, 32'h2222_2222, 0);
    check("rstw_serve", 256'(s_vout), 256'(1));

    // Saturation of the discard counter, then flush coinciding with a dropped response
    for (int i = 0; i < 3; i++) begin
      step(0, 1, mk(meta, 0, 1, 2'd2, 0, 1, 32'h0000_6000), 1, 0, '0, 0);
      step(0, 0, '0, 1, 0, '0, 1);
    end
    step(0, 1, mk(meta, 0, 1, 2'd2, 0, 1, 32'h0000_6000), 1, 0, '0, 0);
    step(0, 0, '0, 1, 1, '0, 1);
    step(0, 1, mk(meta, 0, 1, 2'd2, 0, 1, 32'h0000_6000), 1, 0, '0, 0);
    step(0, 0, '0, 1, 1, 32'h3333_3333, 0);
    step(0, 0, '0, 1, 1, 32'h4444_4444, 0);
    check("sat_drop", 256'(s_vout), 256'(0));
    step(0, 0, '0, 1, 1, 32'h5555_5555, 0);
    check("sat_serve", 256'(s_vout), 256'(1));
    idle(1);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      bit ex, wt, uns;
      logic [1:0] sz;
      logic [X-1:0] res;
      ex  = ($urandom_range(0, 9) == 0);
      wt  = ($urandom_range(0, 9) < 6);
      sz  = 2'($urandom_range(0, 2));
      uns = 1'($urandom);
      res = $urandom;
      res = res & ~X'((32'd1 << sz) - 32'd1);
      e   = mk(rnd_meta(), ex, wt, sz, uns, wt && !ex, res);
      step(($urandom_range(0, 199) == 0), 1'($urandom), e, ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 9) < 3), $urandom, ($urandom_range(0, 19) == 0));
    end

    // 64-bit datapath
    reset_w = 1;
    @(posedge clk); #1;
    reset_w = 0;
    step64("ldw64", 64'h0000_0000_0000_1004, 2'd2, 0, 64'hFFFF_FFFE_0000_0000, 64'hFFFF_FFFF_FFFF_FFFE);
    step64("ldd64", 64'h0000_0000_0000_2000, 2'd3, 0, 64'h8123_4567_89AB_CDEF, 64'h8123_4567_89AB_CDEF);
    step64("ldbu64", 64'h0000_0000_0000_3007, 2'd0, 1, 64'hF100_0000_0000_0000, 64'h0000_0000_0000_00F1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
